// File: rtl/cdc_pulse_data.sv
// Single-clock model of a pulse-plus-data crossing: a 4-phase req/ack handshake
// with configurable synchronizer depth moves one DW-bit word per source pulse.
module cdc_pulse_data #(
    parameter int unsigned DW          = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_din,
    input  logic          s_vld,
    output logic [DW-1:0] d_dout,
    output logic          d_vld,
    output logic          active
);

    // Encoding is {req, active} so both handshake outputs come straight off flops.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b11,
        ST_DRAIN = 2'b01
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   req;
    logic                   accept_c;
    logic                   s_ack;
    logic                   ack;
    logic                   d_req;
    logic                   d_req_prev;
    logic                   d_rise_c;
    logic [SYNC_STAGES-1:0] req_sync;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [DW-1:0]          data_reg;

    // Source handshake state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Source next state: accept, wait for ack high, then wait for ack low.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (s_vld)  state_nxt = ST_REQ;
            ST_REQ:   if (s_ack)  state_nxt = ST_DRAIN;
            ST_DRAIN: if (!s_ack) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Source outputs decoded from the state flops.
    always_comb begin
        req      = state[1];
        active   = state[0];
        accept_c = (state == ST_IDLE) && s_vld;
    end

    // Held from acceptance until the handshake fully retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
        end else if (accept_c) begin
            data_reg <= s_din;
        end
    end

    // Forward and return synchronizer chains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_sync <= '0;
            ack_sync <= '0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], req};
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
        end
    end

    assign d_req    = req_sync[SYNC_STAGES-1];
    assign ack      = d_req;
    assign s_ack    = ack_sync[SYNC_STAGES-1];
    assign d_rise_c = d_req & ~d_req_prev;

    // Destination: one pulse and one data load per rising d_req.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_req_prev <= 1'b0;
            d_vld      <= 1'b0;
            d_dout     <= '0;
        end else begin
            d_req_prev <= d_req;
            d_vld      <= d_rise_c;
            if (d_rise_c) begin
                d_dout <= data_reg;
            end
        end
    end

endmodule

// File: tb/tb_cdc_pulse_data.sv
// Directed and randomized bench for cdc_pulse_data at two synchronizer depths.
module tb_cdc_pulse_data;

    localparam int N_RAND = 4000;

    logic       clk;
    logic       rst;
    logic [7:0] s_din2, s_din3;
    logic       s_vld2, s_vld3;
    logic [7:0] d_dout2, d_dout3;
    logic       d_vld2, d_vld3;
    logic       active2, active3;

    int checks;
    int errors;

    cdc_pulse_data #(.DW(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .s_din(s_din2), .s_vld(s_vld2),
        .d_dout(d_dout2), .d_vld(d_vld2), .active(active2)
    );

    cdc_pulse_data #(.DW(8), .SYNC_STAGES(3)) dut3 (
        .clk(clk), .rst(rst), .s_din(s_din3), .s_vld(s_vld3),
        .d_dout(d_dout3), .d_vld(d_vld3), .active(active3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transfer on the selected instance, checked cycle by cycle against the
    // spec timing: d_vld only after edge k+S+1, active high for 4*S+2 cycles.
    // ign_at >= 0 pulses s_vld with 0x3C just before edge k+ign_at+1.
    task automatic xfer(input int sel, input logic [7:0] v, input int ign_at);
        int         s;
        logic       act, vld;
        logic [7:0] dout;
        s = (sel == 3) ? 3 : 2;
        if (sel == 3) begin s_vld3 = 1'b1; s_din3 = v; end
        else          begin s_vld2 = 1'b1; s_din2 = v; end
        tick();
        s_vld2 = 1'b0; s_vld3 = 1'b0;
        s_din2 = $urandom; s_din3 = $urandom;
        for (int j = 0; j <= 4 * s + 2; j++) begin
            act  = (sel == 3) ? active3 : active2;
            vld  = (sel == 3) ? d_vld3  : d_vld2;
            dout = (sel == 3) ? d_dout3 : d_dout2;
            check($sformatf("active_s%0d_j%0d", s, j), 32'(act), 32'(j <= 4 * s + 1));
            check($sformatf("d_vld_s%0d_j%0d", s, j), 32'(vld), 32'(j == s + 1));
            if (j >= s + 1)
                check($sformatf("d_dout_s%0d_j%0d", s, j), 32'(dout), 32'(v));
            if (j < 4 * s + 2) begin
                if (j == ign_at) begin
                    if (sel == 3) begin s_vld3 = 1'b1; s_din3 = 8'h3C; end
                    else          begin s_vld2 = 1'b1; s_din2 = 8'h3C; end
                end
                tick();
                s_vld2 = 1'b0; s_vld3 = 1'b0;
            end
        end
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            check({tag, "_vld"}, 32'(d_vld2), 32'd0);
            check({tag, "_act"}, 32'(active2), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] seq [3];
        logic [7:0] r;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        s_vld2 = 1'b0; s_vld3 = 1'b0;
        s_din2 = 8'h00; s_din3 = 8'h00;
        tick(); tick();

        // Reset values on both instances.
        check("rst_dout2", 32'(d_dout2), 32'd0);
        check("rst_vld2", 32'(d_vld2), 32'd0);
        check("rst_act2", 32'(active2), 32'd0);
        check("rst_dout3", 32'(d_dout3), 32'd0);
        check("rst_vld3", 32'(d_vld3), 32'd0);
        check("rst_act3", 32'(active3), 32'd0);

        rst = 1'b0;
        tick();

        // Basic transfer, then an ignored pulse while active.
        xfer(2, 8'hA5, -1);
        xfer(2, 8'hA5, 2);
        check_quiet("after_ignore", 12);
        check("hold_A5", 32'(d_dout2), 32'hA5);

        // Back-to-back boundary values.
        seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h5A;
        for (int i = 0; i < 3; i++) xfer(2, seq[i], -1);

        // Reset two cycles into a transfer aborts it.
        s_vld2 = 1'b1; s_din2 = 8'h77;
        tick();
        s_vld2 = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        check("abort_dout", 32'(d_dout2), 32'd0);
        check("abort_vld", 32'(d_vld2), 32'd0);
        check("abort_act", 32'(active2), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_hold_vld", 32'(d_vld2), 32'd0);
            check("abort_hold_dout", 32'(d_dout2), 32'd0);
        end
        rst = 1'b0;
        // s_vld lands on the first edge after release.
        xfer(2, 8'h12, -1);
        check_quiet("after_12", 4);

        // Deeper synchronizer instance.
        xfer(3, 8'h81, -1);

        // Randomized back-to-back traffic.
        for (int n = 0; n < N_RAND; n++) begin
            r = 8'($urandom);
            xfer(2, r, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
